divn_detector: RTL and testbench
================================

Name: divn_detector

Overview:
- Parametrised successor to the serial divide-by-3 detector.
- Tracks a residue modulo DIVISOR over a serial input bit stream, one bit per enabled clock.
- Two modes: count of ones mod N, or the MSB-first binary value of the stream mod N.
- Provides a Mealy flag, a registered Moore flag, a bit/ones counter and a saturating hit counter, for use by lab top-levels driving LEDs and 7-segment displays.

Parameters:
- DIVISOR, 3, modulus N; legal range 2..16.
- CNT_W, 4, width of count and hit_cnt.
- MODE, 0, 0 = ones-count mod N; 1 = serial binary value (MSB first) mod N.
- RW, $clog2(DIVISOR), residue width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- en  in  1  bit-valid; ain is consumed only on cycles where en=1.
- ain  in  1  serial data bit.
- clr  in  1  synchronous soft clear, active-high; same effect as reset.
- yout  out  1  Mealy flag: en & (res_nxt == 0).
- yout_q  out  1  Moore flag: started & (res == 0).
- residue  out  RW  current residue res.
- count  out  CNT_W  accepted events; MODE0 counts ones, MODE1 counts bits; wraps.
- hit_cnt  out  CNT_W  number of accepted bits for which res_nxt==0; saturates at all-ones.

Behaviour:
- **Reset or clr.** reset=0 or clr=1 at an edge: res=0, started=0, count=0, hit_cnt=0. reset has priority over clr, and clr has priority over en.
- **Outputs during/after reset.** yout_q=0 after reset; yout still follows en & (res_nxt==0) combinationally. Callers ignore yout while reset is asserted.
- **Next residue, MODE0:** res_nxt = ain ? (res+1 == N ? 0 : res+1) : res.
- **Next residue, MODE1:** res_nxt = (2*res + ain) mod N, computed in RW+1 bits with a single conditional subtract. Legal because 2*res+ain ≤ 2N-1.
- **en=1 edge updates:**
  - res <= res_nxt; started <= 1.
  - count: MODE0 increments by ain; MODE1 increments by 1. Wraps modulo 2^CNT_W.
  - hit_cnt increments when res_nxt==0 and hit_cnt is not all-ones.
- **en=0 edge:** all state holds; yout=0.
- **Latency.** yout asserts in the same cycle as the qualifying bit. yout_q and hit_cnt reflect that bit one cycle later, after the edge.
- **Equivalent state machine.** N states S0..S(N-1) plus the started flag. MODE0 is a ring advanced on ones. MODE1 is the standard remainder automaton.
- **MODE0 with ain=0 while res=0 and en=1:** yout=1. Zero ones still counts as divisible; this matches the legacy div3 behaviour.
- **Mid-stream reset or clr:** the next accepted bit starts a fresh stream from res=0. No stale yout_q.
- **Illegal parameters.** DIVISOR<2 or >16 trips an elaboration-time $error.

Test Plan:
1. **MODE0, N=3, reset then release.** Hold reset=0 for 2 cycles, then en=1 with ain = 1,1,1,0,1. Required: yout = 0,0,1,1,0; yout_q one cycle later; count = 1,2,3,3,4; hit_cnt ends at 2.
2. **MODE1, N=3, serial binary 1,1,0 (value 6).** Residues 1,0,0; yout=0,1,1; final yout_q=1, count=3.
3. **MODE1, N=5, bits 1,0,1,1 (value 11).** Residues 1,2,0,1; yout only on the 3rd bit; hit_cnt=1.
4. **en gating, MODE0 N=3.** Interleave en=0 cycles with ain=1. Required: residue, count and yout_q unchanged across gaps; yout=0 when en=0.
5. **reset mid-stream.** Drop reset low for 1 cycle after residue=2, at the same edge as en=1, ain=1 and clr=1. Required: res=0, count=0, hit_cnt=0, yout_q=0 next cycle; clr alone gives the identical result.
6. **Saturation/wrap, CNT_W=2, MODE0 N=2.** Feed 10 ones. Required: count wraps (ends at 2); hit_cnt saturates at 3.

Source files
------------

// File: rtl/divn_detector.sv
// Serial divisibility detector: tracks a residue modulo DIVISOR over an enabled bit stream,
// either as a ones-count (MODE 0) or as an MSB-first binary value (MODE 1).
module divn_detector #(
    parameter int DIVISOR = 3,
    parameter int CNT_W   = 4,
    parameter int MODE    = 0,
    localparam int RW     = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ain,
    input  logic             clr,
    output logic             yout,
    output logic             yout_q,
    output logic [RW-1:0]    residue,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] hit_cnt
);

    if (DIVISOR < 2 || DIVISOR > 16) begin : g_bad_divisor
        $error("divn_detector: DIVISOR must be in 2..16");
    end

    localparam logic [RW:0] NVAL = (RW + 1)'(DIVISOR);

    logic [RW-1:0]    res;
    logic [RW-1:0]    res_nxt;
    logic             started;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hits;
    logic [RW:0]      ext;

    // One extra bit covers res+1 == N and 2*res+ain <= 2N-1 without overflow.
    if (MODE == 1) begin : g_binary
        always_comb begin
            ext = {res, ain};
            if (ext >= NVAL) begin
                ext = ext - NVAL;
            end
            res_nxt = ext[RW-1:0];
        end
    end else begin : g_ones
        always_comb begin
            ext = {1'b0, res} + (RW + 1)'(1);
            if (ext == NVAL) begin
                ext = '0;
            end
            res_nxt = ain ? ext[RW-1:0] : res;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            res     <= '0;
            started <= 1'b0;
            cnt     <= '0;
            hits    <= '0;
        end else if (en) begin
            res     <= res_nxt;
            started <= 1'b1;
            if (MODE == 1) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(ain);
            end
            if (res_nxt == '0 && hits != '1) begin
                hits <= hits + CNT_W'(1);
            end
        end
    end

    assign yout    = en & (res_nxt == '0);
    assign yout_q  = started & (res == '0);
    assign residue = res;
    assign count   = cnt;
    assign hit_cnt = hits;

endmodule

// File: tb/tb_divn_detector.sv
// Bench for divn_detector: four parameterisations checked every cycle against an arithmetic
// model (ones total / stream value mod N), plus directed literal expectations.
module tb_divn_detector;

    localparam int NV[4] = '{3, 3, 5, 2};
    localparam int MD[4] = '{0, 1, 1, 0};
    localparam int CW[4] = '{4, 4, 4, 2};

    logic clk = 1'b0;
    logic rst[4];
    logic clr[4];
    logic en[4];
    logic ain[4];
    logic yo[4];
    logic yq[4];
    logic [1:0] res0, res1;
    logic [2:0] res2;
    logic [0:0] res3;
    logic [3:0] cnt0, cnt1, cnt2, hit0, hit1, hit2;
    logic [1:0] cnt3, hit3;
    int resv[4], cntv[4], hitv[4];

    int checks = 0;
    int failures = 0;

    // model state
    longint ones[4], bits[4], value[4], hits[4];
    bit started[4];

    always #5 clk = ~clk;

    divn_detector #(.DIVISOR(3), .CNT_W(4), .MODE(0)) u0 (
        .clk(clk), .reset(rst[0]), .en(en[0]), .ain(ain[0]), .clr(clr[0]),
        .yout(yo[0]), .yout_q(yq[0]), .residue(res0), .count(cnt0), .hit_cnt(hit0));
    divn_detector #(.DIVISOR(3), .CNT_W(4), .MODE(1)) u1 (
        .clk(clk), .reset(rst[1]), .en(en[1]), .ain(ain[1]), .clr(clr[1]),
        .yout(yo[1]), .yout_q(yq[1]), .residue(res1), .count(cnt1), .hit_cnt(hit1));
    divn_detector #(.DIVISOR(5), .CNT_W(4), .MODE(1)) u2 (
        .clk(clk), .reset(rst[2]), .en(en[2]), .ain(ain[2]), .clr(clr[2]),
        .yout(yo[2]), .yout_q(yq[2]), .residue(res2), .count(cnt2), .hit_cnt(hit2));
    divn_detector #(.DIVISOR(2), .CNT_W(2), .MODE(0)) u3 (
        .clk(clk), .reset(rst[3]), .en(en[3]), .ain(ain[3]), .clr(clr[3]),
        .yout(yo[3]), .yout_q(yq[3]), .residue(res3), .count(cnt3), .hit_cnt(hit3));

    always_comb begin
        resv[0] = int'(res0); resv[1] = int'(res1); resv[2] = int'(res2); resv[3] = int'(res3);
        cntv[0] = int'(cnt0); cntv[1] = int'(cnt1); cntv[2] = int'(cnt2); cntv[3] = int'(cnt3);
        hitv[0] = int'(hit0); hitv[1] = int'(hit1); hitv[2] = int'(hit2); hitv[3] = int'(hit3);
    end

    function automatic int model_res(input int k);
        return MD[k] == 1 ? int'(value[k] % NV[k]) : int'(ones[k] % NV[k]);
    endfunction

    function automatic int model_res_after(input int k, input logic a);
        return MD[k] == 1 ? int'((value[k] * 2 + longint'(a)) % NV[k])
                          : int'((ones[k] + longint'(a)) % NV[k]);
    endfunction

    task automatic check(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d exp=%0d at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst[k] || clr[k]) begin
                ones[k] = 0; bits[k] = 0; value[k] = 0; hits[k] = 0; started[k] = 0;
            end else if (en[k]) begin
                if (model_res_after(k, ain[k]) == 0) hits[k]++;
                ones[k]  += longint'(ain[k]);
                value[k]  = value[k] * 2 + longint'(ain[k]);
                bits[k]++;
                started[k] = 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int maxc;
            maxc = (1 << CW[k]) - 1;
            check("yout", k, int'(yo[k]),
                  int'(en[k] && model_res_after(k, ain[k]) == 0));
            check("yout_q", k, int'(yq[k]), int'(started[k] && model_res(k) == 0));
            check("residue", k, resv[k], model_res(k));
            check("count", k, cntv[k],
                  int'((MD[k] == 1 ? bits[k] : ones[k]) % longint'(maxc + 1)));
            check("hit_cnt", k, hitv[k], hits[k] > maxc ? maxc : int'(hits[k]));
        end
    end

    task automatic drive(input int k, input logic r, input logic c, input logic e,
                         input logic a, input int ey);
        rst[k] = r; clr[k] = c; en[k] = e; ain[k] = a;
        @(negedge clk);
        if (ey >= 0) check("yout_lit", k, int'(yo[k]), ey);
        @(posedge clk);
        #1;
        rst[k] = 1'b1; clr[k] = 1'b0; en[k] = 1'b0; ain[k] = 1'b0;
    endtask

    task automatic check_cleared(input int k);
        check("clr_res", k, resv[k], 0);
        check("clr_cnt", k, cntv[k], 0);
        check("clr_hit", k, hitv[k], 0);
        check("clr_yq", k, int'(yq[k]), 0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b0; clr[k] = 1'b0; en[k] = 1'b0; ain[k] = 1'b0;
            ones[k] = 0; bits[k] = 0; value[k] = 0; hits[k] = 0; started[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) rst[k] = 1'b1;
        for (int k = 0; k < 4; k++) check_cleared(k);

        // MODE0 N=3: ones 1,1,1,0,1
        drive(0, 1, 0, 1, 1, 0); check("t1_cnt", 0, cntv[0], 1);
        drive(0, 1, 0, 1, 1, 0); check("t1_cnt", 0, cntv[0], 2);
        drive(0, 1, 0, 1, 1, 1); check("t1_cnt", 0, cntv[0], 3); check("t1_yq", 0, int'(yq[0]), 1);
        drive(0, 1, 0, 1, 0, 1); check("t1_cnt", 0, cntv[0], 3); check("t1_yq", 0, int'(yq[0]), 1);
        drive(0, 1, 0, 1, 1, 0); check("t1_cnt", 0, cntv[0], 4); check("t1_hit", 0, hitv[0], 2);
        check("t1_yq", 0, int'(yq[0]), 0);

        // MODE1 N=3: 1,1,0 = 6
        drive(1, 1, 0, 1, 1, 0); check("t2_res", 1, resv[1], 1);
        drive(1, 1, 0, 1, 1, 1); check("t2_res", 1, resv[1], 0);
        drive(1, 1, 0, 1, 0, 1); check("t2_res", 1, resv[1], 0);
        check("t2_yq", 1, int'(yq[1]), 1); check("t2_cnt", 1, cntv[1], 3);

        // MODE1 N=5: 1,0,1,1 = 11
        drive(2, 1, 0, 1, 1, 0); check("t3_res", 2, resv[2], 1);
        drive(2, 1, 0, 1, 0, 0); check("t3_res", 2, resv[2], 2);
        drive(2, 1, 0, 1, 1, 1); check("t3_res", 2, resv[2], 0);
        drive(2, 1, 0, 1, 1, 0); check("t3_res", 2, resv[2], 1);
        check("t3_hit", 2, hitv[2], 1);

        // en gating on instance 0 (residue 1, count 4)
        drive(0, 1, 0, 0, 1, 0); check("t4_res", 0, resv[0], 1); check("t4_cnt", 0, cntv[0], 4);
        drive(0, 1, 0, 1, 1, 0); check("t4_res", 0, resv[0], 2);
        drive(0, 1, 0, 0, 1, 0); drive(0, 1, 0, 0, 1, 0);
        check("t4_res", 0, resv[0], 2); check("t4_cnt", 0, cntv[0], 5);
        drive(0, 1, 0, 1, 1, 1); check("t4_yq", 0, int'(yq[0]), 1);
        drive(0, 1, 0, 0, 1, 0); check("t4_yq", 0, int'(yq[0]), 1);

        // mid-stream reset colliding with en and clr, then clr alone
        drive(0, 1, 1, 0, 0, -1);
        drive(0, 1, 0, 1, 1, 0); drive(0, 1, 0, 1, 1, 0);
        check("t5_res", 0, resv[0], 2);
        drive(0, 0, 1, 1, 1, -1); check_cleared(0);
        drive(0, 1, 0, 1, 1, 0); drive(0, 1, 0, 1, 1, 0);
        check("t5_res", 0, resv[0], 2);
        drive(0, 1, 1, 1, 1, -1); check_cleared(0);
        drive(0, 1, 0, 1, 0, 1); check("t5_yq", 0, int'(yq[0]), 1);

        // CNT_W=2, N=2: ten ones
        for (int i = 0; i < 10; i++) drive(3, 1, 0, 1, 1, (i % 2 == 1) ? 1 : 0);
        check("t6_cnt", 3, cntv[3], 2);
        check("t6_hit", 3, hitv[3], 3);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
